// File: rtl/alu_pkg.sv
// Shared ALU datapath definitions: divider FSM encoding and sizing helpers.
package alu_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CALC   = 2'd1,
    ST_FINISH = 2'd2
  } div_state_e;

  // Step counter must hold 0..width-1 with a spare bit of headroom.
  function automatic int cnt_width(input int width);
    return $clog2(width) + 1;
  endfunction

  localparam int DEFAULT_CNT_W = cnt_width(DEFAULT_WIDTH);

endpackage

// File: rtl/unsigned_div_step.sv
// One combinational restoring-division step on unsigned magnitudes.
module unsigned_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_prev,
  input  logic             dividend_bit,
  input  logic [WIDTH-1:0] divisor_mag,
  output logic [WIDTH-1:0] rem_next,
  output logic             q_bit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // rem_prev < divisor_mag, so the shifted value needs one extra bit and
  // a non-negative difference always fits back into WIDTH bits.
  assign shifted  = {rem_prev, dividend_bit};
  assign diff     = shifted - {1'b0, divisor_mag};
  assign q_bit    = ~diff[WIDTH];
  assign rem_next = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/signed_number_32_bit_divider.sv
// Sequential signed divider: restoring division on magnitudes, one quotient
// bit per clock, then sign correction. Start/done handshake like the multiplier.
//
// state     | meaning
// ST_IDLE   | waiting for start; results from last operation held
// ST_CALC   | one restoring step per clock, WIDTH steps total
// ST_FINISH | apply signs, pulse done, return to idle
module signed_number_32_bit_divider
  import alu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             done,
  output logic             busy,
  output logic             div_by_zero
);

  localparam int CW = cnt_width(WIDTH);

  div_state_e     state;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] r_mag;
  logic [CW-1:0]    count;
  logic             sign_q;
  logic             sign_r;
  logic [WIDTH-1:0] rem_next;
  logic             q_bit;

  unsigned_div_step #(.WIDTH(WIDTH)) u_step (
    .rem_prev     (r_mag),
    .dividend_bit (a_mag[WIDTH-1]),
    .divisor_mag  (b_mag),
    .rem_next     (rem_next),
    .q_bit        (q_bit)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      a_mag       <= '0;
      b_mag       <= '0;
      r_mag       <= '0;
      count       <= '0;
      sign_q      <= 1'b0;
      sign_r      <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      done        <= 1'b0;
      busy        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            a_mag  <= dividend[WIDTH-1] ? -dividend : dividend;
            b_mag  <= divisor[WIDTH-1] ? -divisor : divisor;
            sign_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            sign_r <= dividend[WIDTH-1];
            r_mag  <= '0;
            count  <= '0;
            busy   <= 1'b1;
            state  <= (divisor == '0) ? ST_FINISH : ST_CALC;
          end
        end
        ST_CALC: begin
          // a_mag doubles as the quotient shift register as dividend bits leave it.
          a_mag <= {a_mag[WIDTH-2:0], q_bit};
          r_mag <= rem_next;
          count <= count + 1'b1;
          if (count == CW'(WIDTH - 1)) state <= ST_FINISH;
        end
        ST_FINISH: begin
          if (b_mag == '0) begin
            // a_mag still holds |dividend|; re-signing restores the original.
            quotient    <= '1;
            remainder   <= sign_r ? -a_mag : a_mag;
            div_by_zero <= 1'b1;
          end else begin
            quotient  <= sign_q ? -a_mag : a_mag;
            remainder <= sign_r ? -r_mag : r_mag;
          end
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
